rv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V core, replacing the bare PC register / PC+4 adder / instruction-memory path with a decoupled unit. Issues word fetches over a valid/ready request port with in-order responses, buffers returned instructions with their PCs in a prefetch FIFO, and hands them to decode over a valid/ready port. Supports pipeline redirects (branch/jump), flushing buffered and in-flight fetches.

---
 rtl/rv_fetch_pkg.sv | 19 +
 rtl/rv_fetch_fifo.sv | 61 ++++++
 rtl/rv_fetch_unit.sv | 126 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package rv_fetch_pkg;

   localparam int FETCH_XLEN    = 32;
   localparam int ILEN          = 32;
   localparam int DEFAULT_DEPTH = 4;
   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [ILEN-1:0]       inst;
   } fetch_entry_t;

   // Counters must represent 0..DEPTH inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with push/pop/flush and occupancy output.
// Read is combinational from the head entry; outputs read as zero while empty.
module rv_fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int XLEN  = FETCH_XLEN,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [XLEN-1:0]  i_push_pc,
   input  logic [ILEN-1:0]  i_push_inst,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count,
   output logic [XLEN-1:0]  o_pc,
   output logic [ILEN-1:0]  o_inst
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0]  r_pc_mem   [DEPTH];
   logic [ILEN-1:0]  r_inst_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_pc_mem[r_wr_ptr]   <= i_push_pc;
         r_inst_mem[r_wr_ptr] <= i_push_inst;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_pc    = o_empty ? '0 : r_pc_mem[r_rd_ptr];
   assign o_inst  = o_empty ? '0 : r_inst_mem[r_rd_ptr];

endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled instruction-fetch front end: credit-limited requests, prefetch FIFO,
// redirect flush. Optional perf counters when FETCH_PERF_CNT_EN is defined.
module rv_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int              XLEN         = FETCH_XLEN,
   parameter int              DEPTH        = DEFAULT_DEPTH,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [ILEN-1:0] mem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_flushed
`endif
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_rsp_pc;
   logic [CNT_W-1:0] r_inflight;
   logic [CNT_W-1:0] r_discard;

   logic [CNT_W-1:0] w_occ;
   logic             w_empty;
   logic             w_credit;
   logic             w_req_fire;
   logic             w_push;
   logic             w_pop;
   logic [XLEN-1:0]  w_redirect_pc;

   // Occupancy plus outstanding requests never exceeds DEPTH, so a push always fits.
   assign w_credit      = ({1'b0, w_occ} + {1'b0, r_inflight}) < DEPTH_C;
   assign mem_req_valid = !reset && !redirect_valid && w_credit;
   assign mem_req_addr  = r_fetch_pc;
   assign w_req_fire    = mem_req_valid && mem_req_ready;

   assign w_push        = mem_rsp_valid && !redirect_valid && (r_discard == '0);
   assign inst_valid    = !w_empty && !redirect_valid;
   assign w_pop         = inst_valid && inst_ready;
   assign w_redirect_pc = redirect_pc & ~XLEN'(3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_VECTOR;
         r_rsp_pc   <= RESET_VECTOR;
         r_inflight <= '0;
         r_discard  <= '0;
      end else begin
         r_inflight <= r_inflight + CNT_W'(w_req_fire) - CNT_W'(mem_rsp_valid);
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            // Everything still outstanding after this cycle belongs to the old stream.
            r_discard  <= r_inflight - CNT_W'(mem_rsp_valid);
         end else begin
            if (w_req_fire)
               r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_push)
               r_rsp_pc <= r_rsp_pc + XLEN'(4);
            if (mem_rsp_valid && (r_discard != '0))
               r_discard <= r_discard - CNT_W'(1);
         end
      end
   end

   rv_fetch_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_pc   (r_rsp_pc),
      .i_push_inst (mem_rsp_data),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .o_empty     (w_empty),
      .o_count     (w_occ),
      .o_pc        (inst_pc),
      .o_inst      (inst_data)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0]  r_perf_fetched;
   logic [31:0]  r_perf_flushed;
   logic         w_drop_rsp;
   logic [CNT_W:0] w_flush_add;
   logic [32:0]  w_fetched_sum;
   logic [32:0]  w_flushed_sum;

   assign w_drop_rsp    = mem_rsp_valid && (r_discard != '0);
   assign w_flush_add   = redirect_valid ? ({1'b0, w_occ} + (CNT_W+1)'(mem_rsp_valid))
                                         : (CNT_W+1)'(w_drop_rsp);
   assign w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_pop);
   assign w_flushed_sum = {1'b0, r_perf_flushed} + 33'(w_flush_add);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_fetched <= '0;
         r_perf_flushed <= '0;
      end else begin
         r_perf_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
         r_perf_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit: directed phases push expected {pc,inst},
// a monitor pops and compares on every instruction handshake.
module tb_rv_fetch_unit;
   import rv_fetch_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [31:0] mem_req_addr, mem_rsp_data;
   logic        inst_valid, inst_ready, redirect_valid;
   logic [31:0] inst_data, inst_pc, redirect_pc;

   logic        mem_req_valid_b, mem_rsp_valid_b, inst_valid_b;
   logic [31:0] mem_req_addr_b, mem_rsp_data_b, inst_data_b, inst_pc_b;
   logic        mem_req_ready_b = 1'b1;
   logic        inst_ready_b    = 1'b1;
   logic        redirect_valid_b = 1'b0;
   logic [31:0] redirect_pc_b   = 32'h0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_flushed, perf_fetched_b, perf_flushed_b;
`endif

   rv_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
   );

   rv_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready_b), .mem_req_addr(mem_req_addr_b),
      .mem_rsp_valid(mem_rsp_valid_b), .mem_rsp_data(mem_rsp_data_b),
      .inst_valid(inst_valid_b), .inst_ready(inst_ready_b), .inst_data(inst_data_b), .inst_pc(inst_pc_b),
      .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched_b), .perf_flushed(perf_flushed_b)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_deliv  = 0;
   fetch_entry_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, inst: pc});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (6) @(negedge clk);
   endtask

   // Memory A: in-order, fixed latency, returns the address as the instruction.
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int    cyc     = 0;
   int    mem_lat = 1;

   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         mem_rsp_valid = 1'b0;
         if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mq[0].addr;
            void'(mq.pop_front());
         end
         @(negedge clk);
         if (reset)
            mq.delete();
         else if (mem_req_valid && mem_req_ready)
            mq.push_back('{mem_req_addr, cyc + mem_lat});
      end
   end

   // Memory B: always ready, one-cycle latency.
   logic        b_acc;
   logic [31:0] b_addr;
   initial begin
      mem_rsp_valid_b = 1'b0;
      mem_rsp_data_b  = 32'h0;
      b_acc = 1'b0;
      b_addr = 32'h0;
      forever begin
         @(negedge clk);
         b_acc  = !reset && mem_req_valid_b;
         b_addr = mem_req_addr_b;
         @(posedge clk);
         #1;
         mem_rsp_valid_b = b_acc && !reset;
         mem_rsp_data_b  = b_addr;
      end
   end

   // Scoreboard monitor for instance A.
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         if (!reset && inst_valid && inst_ready) begin
            n_deliv++;
            $display("deliver pc=%08h inst=%08h", inst_pc, inst_data);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_inst: got pc %08h, required no delivery", inst_pc);
            end else begin
               e = exp_q.pop_front();
               check("inst_pc", 64'(inst_pc), 64'(e.pc));
               check("inst_data", 64'(inst_data), 64'(e.inst));
            end
         end
      end
   end

   // Wrap-around monitor for instance B: first four deliveries after reset.
   int n_b = 0;
   logic [31:0] exp_b [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && inst_valid_b && n_b < 4) begin
            $display("wrap deliver pc=%08h", inst_pc_b);
            check("wrap_pc", 64'(inst_pc_b), 64'(exp_b[n_b]));
            check("wrap_data", 64'(inst_data_b), 64'(exp_b[n_b]));
            n_b++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int first = 0;
      int cnt   = 0;
      int acc   = 0;
      reset = 1'b1;
      mem_req_ready = 1'b1;
      inst_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_req_addr", 64'(mem_req_addr), 64'd0);
      check("rst_inst_valid", 64'(inst_valid), 64'd0);
      check("rst_inst_data", 64'(inst_data), 64'd0);
      check("rst_inst_pc", 64'(inst_pc), 64'd0);
      check("rst_wrap_addr", 64'(mem_req_addr_b), 64'hFFFF_FFF8);

      // Streaming: 8 requests accepted, one delivery per cycle from cycle 3.
      for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) tick();
         if (c == 9) mem_req_ready = 1'b0;
         @(negedge clk);
         if (c == 1) begin
            check("first_req_valid", 64'(mem_req_valid), 64'd1);
            check("first_req_addr", 64'(mem_req_addr), 64'd0);
         end
         if (inst_valid) begin
            cnt++;
            if (first == 0) first = c;
         end
      end
      check("first_valid_cycle", 64'(first), 64'd3);
      check("stream_count", 64'(cnt), 64'd8);
      wait_drain();

      // Decode stalled: only DEPTH requests accepted.
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) begin
            inst_ready = 1'b0;
            mem_req_ready = 1'b1;
         end
         @(negedge clk);
         if (mem_req_valid && mem_req_ready) acc++;
      end
      check("credit_accepts", 64'(acc), 64'd4);
      check("credit_req_valid", 64'(mem_req_valid), 64'd0);
      check("stall_head_pc", 64'(inst_pc), 64'h20);
      for (int i = 0; i < 4; i++) push_exp(32'h20 + 32'(i * 4));
      tick();
      mem_req_ready = 1'b0;
      inst_ready = 1'b1;
      wait_drain();

      // Memory not ready: address held.
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("hold_valid", 64'(mem_req_valid), 64'd1);
         check("hold_addr", 64'(mem_req_addr), 64'h30);
      end
      tick();
      mem_req_ready = 1'b1;
      push_exp(32'h30);
      tick();
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("addr_advance", 64'(mem_req_addr), 64'h34);
      wait_drain();

      // Redirect with 3 in flight on 3-cycle memory.
      tick();
      mem_lat = 3;
      mem_req_ready = 1'b1;
      tick();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      @(negedge clk);
      check("redirect_blocks_req", 64'(mem_req_valid), 64'd0);
      tick();
      redirect_valid = 1'b0;
      push_exp(32'h100);
      push_exp(32'h104);
      @(negedge clk);
      check("redirect_req_addr", 64'(mem_req_addr), 64'h100);
      tick();
      tick();
      mem_req_ready = 1'b0;
      wait_drain();
`ifdef FETCH_PERF_CNT_EN
      check("perf_flushed_a", 64'(perf_flushed), 64'd3);
`endif

      // Redirect coinciding with a response and a would-be pop.
      tick();
      mem_lat = 1;
      inst_ready = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      tick();
      mem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      inst_ready = 1'b1;
      @(negedge clk);
      check("no_pop_on_redirect", 64'(inst_valid), 64'd0);
      tick();
      redirect_valid = 1'b0;
      mem_req_ready = 1'b1;
      push_exp(32'h200);
      @(negedge clk);
      check("post_redirect_n1", 64'(inst_valid), 64'd0);
      tick();
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("post_redirect_n2", 64'(inst_valid), 64'd0);
      tick();
      @(negedge clk);
      check("redirect_latency", 64'(inst_valid), 64'd1);
      check("redirect_first_pc", 64'(inst_pc), 64'h200);
      wait_drain();
`ifdef FETCH_PERF_CNT_EN
      check("perf_flushed_b", 64'(perf_flushed), 64'd5);
      check("perf_fetched", 64'(perf_fetched), 64'(n_deliv));
`endif

      // Reset mid-operation with two requests outstanding.
      tick();
      mem_lat = 3;
      inst_ready = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("midrst_req_valid", 64'(mem_req_valid), 64'd0);
      check("midrst_req_addr", 64'(mem_req_addr), 64'd0);
      check("midrst_inst_valid", 64'(inst_valid), 64'd0);
      check("midrst_inst_pc", 64'(inst_pc), 64'd0);
`ifdef FETCH_PERF_CNT_EN
      check("midrst_perf", 64'(perf_fetched), 64'd0);
`endif
      tick();
      reset = 1'b0;
      mem_req_ready = 1'b1;
      inst_ready = 1'b1;
      push_exp(32'h0);
      @(negedge clk);
      check("restart_req_valid", 64'(mem_req_valid), 64'd1);
      check("restart_req_addr", 64'(mem_req_addr), 64'd0);
      tick();
      mem_req_ready = 1'b0;
      wait_drain();

      check("wrap_count", 64'(n_b), 64'd4);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
